// File: rtl/invaes_keysched_if.sv
// invaes_keysched_if: start/key handshake and round-key read port of the AES key-schedule engine.
interface invaes_keysched_if #(
    parameter int K = 256
);
    logic           start;
    logic [K-1:0]   key;
    logic           busy;
    logic           ready;
    logic [3:0]     rd_round;
    logic [127:0]   rd_key;
    modport master (output start, key, rd_round, input busy, ready, rd_key);
    modport slave  (input start, key, rd_round, output busy, ready, rd_key);
endinterface

// File: rtl/invaes_keysched.sv
// invaes_keysched: iterative AES-128/192/256 key expansion, one word per cycle, with a registered indexed read port.
// Define INVAES_KEYSCHED_EQINV_EN to return InvMixColumns'd middle round keys for the equivalent inverse cipher.
module invaes_keysched #(
    parameter int K = 256
) (
    input  logic             clk,
    input  logic             reset,
    invaes_keysched_if.slave bus
);
    localparam int NK = K / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] LAST_W = 6'(NW - 1);
    localparam logic [2:0] LAST_J = 3'(NK - 1);
    localparam logic [3:0] NR_R   = 4'(NR);

    generate
        if (K != 128 && K != 192 && K != 256) begin : g_bad_k
            $error("invaes_keysched: K must be 128, 192 or 256");
        end
    endgenerate

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

    state_t         state_q, state_d;
    logic [5:0]     i_q, i_d;
    logic [2:0]     j_q, j_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [K-1:0]   key_q;
    logic [31:0]    w_q [NW];
    logic [127:0]   rd_key_q, rd_key_d;
    logic [31:0]    t, sub_in, sw, new_w;
    logic [3:0]     r_s;
    logic [5:0]     base;
    logic [127:0]   raw;
    logic           start_ok;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

`ifdef INVAES_KEYSCHED_EQINV_EN
    function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
                                 gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
                                 gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
                                 gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
        end
        return o;
    endfunction
`endif

    // j_q tracks i mod Nk and rcon_q tracks Rcon[i/Nk], so no divider is needed
    always_comb begin
        t      = w_q[i_q - 6'd1];
        sub_in = (j_q == 3'd0) ? {t[23:0], t[31:24]} : t;
        sw     = {SBOX[sub_in[31:24]], SBOX[sub_in[23:16]], SBOX[sub_in[15:8]], SBOX[sub_in[7:0]]};
        new_w  = w_q[i_q - NK_W] ^ ((j_q == 3'd0) ? sw ^ {rcon_q, 24'h0}
                                  : (NK == 8 && j_q == 3'd4) ? sw : t);
    end

    assign start_ok = bus.start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        rcon_d  = rcon_q;
        case (state_q)
            IDLE, DONE: if (bus.start) state_d = LOAD;
            LOAD: begin
                state_d = EXPAND;
                i_d     = NK_W;
                j_d     = 3'd0;
                rcon_d  = 8'h01;
            end
            default: begin
                i_d    = i_q + 6'd1;
                j_d    = (j_q == LAST_J) ? 3'd0 : j_q + 3'd1;
                rcon_d = (j_q == 3'd0) ? xt(rcon_q) : rcon_q;
                if (i_q == LAST_W) state_d = DONE;
            end
        endcase
    end

    always_comb begin
        r_s  = (bus.rd_round > NR_R) ? 4'd0 : bus.rd_round;
        base = {r_s, 2'b00};
        raw  = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
`ifdef INVAES_KEYSCHED_EQINV_EN
        rd_key_d = (r_s != 4'd0 && r_s != NR_R) ? inv_mix(raw) : raw;
`else
        rd_key_d = raw;
`endif
        if (state_q != DONE || bus.rd_round > NR_R) rd_key_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            rcon_q   <= '0;
            rd_key_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            rcon_q   <= rcon_d;
            rd_key_q <= rd_key_d;
        end
    end

    // word storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (start_ok && !reset) key_q <= bus.key;
        if (state_q == LOAD) for (int n = 0; n < NK; n++) w_q[n] <= key_q[K-1-32*n -: 32];
        if (state_q == EXPAND) w_q[i_q] <= new_w;
    end

    assign bus.busy   = (state_q == LOAD) || (state_q == EXPAND);
    assign bus.ready  = (state_q == DONE);
    assign bus.rd_key = rd_key_q;
endmodule

// File: tb/tb_invaes_keysched.sv
// tb_invaes_keysched: directed vectors for K=128/192/256 key expansion, latency, read port and reset corners.
`timescale 1ns/1ps
module tb_invaes_keysched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    invaes_keysched_if #(.K(128)) b128 ();
    invaes_keysched_if #(.K(192)) b192 ();
    invaes_keysched_if #(.K(256)) b256 ();

    invaes_keysched #(.K(128)) u128 (.clk(clk), .reset(reset), .bus(b128));
    invaes_keysched #(.K(192)) u192 (.clk(clk), .reset(reset), .bus(b192));
    invaes_keysched #(.K(256)) u256 (.clk(clk), .reset(reset), .bus(b256));

`ifdef INVAES_KEYSCHED_EQINV_EN
    localparam bit EQ = 1'b1;
`else
    localparam bit EQ = 1'b0;
`endif

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [127:0] rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct {
        int           d;
        logic [3:0]   r;
        logic [127:0] e;
    } vec_t;

    vec_t vt [$];
    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] imc(input logic [127:0] s);
        logic [7:0]   m [4];
        logic [7:0]   acc;
        logic [127:0] o;
        m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc ^= gmul(s[127-32*c-8*k -: 8], m[(k - r + 4) % 4]);
                o[127-32*c-8*r -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] exp128(input int r);
        return (EQ && r >= 1 && r <= 9) ? imc(rk[r]) : rk[r];
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input int d, input int r, input logic [127:0] e);
        vec_t v;
        v.d = d;
        v.r = 4'(r);
        v.e = e;
        vt.push_back(v);
    endtask

    task automatic rd(input int d, input logic [3:0] r, output logic [127:0] v);
        b128.rd_round = r;
        b192.rd_round = r;
        b256.rd_round = r;
        @(posedge clk);
        #1;
        v = (d == 0) ? b128.rd_key : (d == 1) ? b192.rd_key : b256.rd_key;
    endtask

    // restart the K=128 engine; optionally pulse start again (with a junk key) at cycle pulse_at
    task automatic run128(input int pulse_at, output int lat);
        b128.key   = K128;
        b128.start = 1'b1;
        @(posedge clk);
        #1;
        b128.start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 80 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) chk("ready_drops_after_start", {b128.busy, b128.ready}, 2'b10);
            if (n == pulse_at) begin
                b128.key   = '1;
                b128.start = 1'b1;
            end else b128.start = 1'b0;
            if (b128.ready) lat = n;
        end
        b128.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [127:0] v;
        int lat [3];
        int l;
        b128.start = 1'b0; b192.start = 1'b0; b256.start = 1'b0;
        b128.key = '0; b192.key = '0; b256.key = '0;
        b128.rd_round = 4'd0; b192.rd_round = 4'd0; b256.rd_round = 4'd0;
        for (int r = 0; r <= 11; r++) add(0, r, (r <= 10) ? exp128(r) : 128'h0);
        add(0, 15, 128'h0);
        add(1, 0, K192[191:64]);
        add(1, 12, 128'he98ba06f448c773c8ecc720401002202);
        add(1, 13, 128'h0);
        add(1, 15, 128'h0);
        add(2, 0, K256[255:128]);
        add(2, 1, EQ ? imc(K256[127:0]) : K256[127:0]);
        add(2, 14, 128'hfe4890d1e6188d0b046df344706c631e);
        add(2, 15, 128'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {b128.busy, b128.ready, b192.busy, b192.ready, b256.busy, b256.ready}, 6'b0);
        chk("reset_rd_key", b128.rd_key | b192.rd_key | b256.rd_key, 128'h0);
        reset = 1'b0;
        b128.key = K128; b192.key = K192; b256.key = K256;
        b128.rd_round = 4'd10; b192.rd_round = 4'd12; b256.rd_round = 4'd14;
        b128.start = 1'b1; b192.start = 1'b1; b256.start = 1'b1;
        @(posedge clk);
        #1;
        b128.start = 1'b0; b192.start = 1'b0; b256.start = 1'b0;
        lat = '{0, 0, 0};
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            #1;
            if (n == 5) begin
                chk("busy_during_expand", {b128.busy, b192.busy, b256.busy, b128.ready, b192.ready, b256.ready}, 6'b111000);
                chk("read_while_busy", b128.rd_key | b192.rd_key | b256.rd_key, 128'h0);
            end
            if (b128.ready && lat[0] == 0) lat[0] = n;
            if (b192.ready && lat[1] == 0) lat[1] = n;
            if (b256.ready && lat[2] == 0) lat[2] = n;
        end
        chk("latency_k128", 128'(lat[0]), 128'd41);
        chk("latency_k192", 128'(lat[1]), 128'd47);
        chk("latency_k256", 128'(lat[2]), 128'd53);
        foreach (vt[x]) begin
            rd(vt[x].d, vt[x].r, v);
            chk($sformatf("vec%0d_k%0d_round%0d", x, 128 + 64 * vt[x].d, vt[x].r), v, vt[x].e);
        end
        run128(10, l);
        chk("latency_with_ignored_start", 128'(l), 128'd41);
        rd(0, 4'd10, v);
        chk("round10_after_ignored_start", v, exp128(10));
        rd(0, 4'd0, v);
        chk("round0_key_not_resampled", v, K128);
        b128.start = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        b128.start = 1'b0;
        reset = 1'b0;
        chk("reset_beats_start", {b128.busy, b128.ready}, 2'b00);
        @(posedge clk);
        #1;
        chk("idle_after_reset_start", {b128.busy, b128.ready}, 2'b00);
        b128.key = K128;
        b128.start = 1'b1;
        @(posedge clk);
        #1;
        b128.start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("busy_before_abort", {b128.busy, b128.ready}, 2'b10);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_mid_expand", {b128.busy, b128.ready}, 2'b00);
        chk("abort_rd_key_zero", b128.rd_key, 128'h0);
        run128(0, l);
        chk("latency_after_abort", 128'(l), 128'd41);
        rd(0, 4'd10, v);
        chk("round10_after_abort", v, exp128(10));
        rd(0, 4'd5, v);
        chk("round5_after_abort", v, exp128(5));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
